// File: rtl/clock_pkg.sv
// Shared widths, limits, reset values and edit-state codes for the
// time-of-day / alarm controller.
package clock_pkg;

    localparam int unsigned HR_W   = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned RING_W = 8;

    localparam logic [HR_W-1:0]  HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX  = 6'd59;

    localparam logic [HR_W-1:0]  AL_HR_RST  = 5'd6;
    localparam logic [MIN_W-1:0] AL_MIN_RST = 6'd30;

    localparam int unsigned ALARM_LEN_DEF = 60;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_SET_HR     = 3'd1,
        ST_SET_MIN    = 3'd2,
        ST_SET_AL_HR  = 3'd3,
        ST_SET_AL_MIN = 3'd4
    } state_e;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up-counter; wrap flags the increment that rolls MAX back to 0.
module wrap_counter #(
    parameter int unsigned     W       = 6,
    parameter logic [W-1:0]    MAX     = '1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] value_q, value_d;

    assign wrap = inc && (value_q == MAX);

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = wrap ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= RST_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/alarm_time_controller.sv
// Time-of-day clock with alarm: MODE steps through the edit fields, INC bumps
// the selected field, and alarm_ring runs for ALARM_LEN seconds on a match.
module alarm_time_controller
    import clock_pkg::*;
#(
    parameter int unsigned ALARM_LEN = ALARM_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sec_tick,
    input  logic             mode_pulse,
    input  logic             inc_pulse,
    input  logic             alarm_en_sw,
    output logic [HR_W-1:0]  hours,
    output logic [MIN_W-1:0] minutes,
    output logic [MIN_W-1:0] seconds,
    output logic [HR_W-1:0]  al_hours,
    output logic [MIN_W-1:0] al_minutes,
    output logic [2:0]       edit_field,
    output logic             alarm_ring
);

    state_e state_q, state_d;

    logic              ring_q, ring_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;

    logic tick_en, edit_pulse, sec_clr;
    logic sec_inc, min_inc, hr_inc, al_hr_inc, al_min_inc;
    logic sec_wrap, min_wrap, hr_wrap;
    logic unused_al_hr_wrap, unused_al_min_wrap;
    logic ring_clear, ring_start;
    logic [MIN_W-1:0] min_next;
    logic [HR_W-1:0]  hr_next;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:        if (mode_pulse) state_d = ST_SET_HR;
            ST_SET_HR:     if (mode_pulse) state_d = ST_SET_MIN;
            ST_SET_MIN:    if (mode_pulse) state_d = ST_SET_AL_HR;
            ST_SET_AL_HR:  if (mode_pulse) state_d = ST_SET_AL_MIN;
            ST_SET_AL_MIN: if (mode_pulse) state_d = ST_RUN;
            default:       state_d = ST_RUN;
        endcase
    end

    // Time is frozen while the running hour/minute are being edited.
    assign tick_en    = sec_tick && ((state_q == ST_RUN) || (state_q == ST_SET_AL_HR)
                                     || (state_q == ST_SET_AL_MIN));
    assign edit_pulse = inc_pulse && !mode_pulse;
    assign sec_clr    = mode_pulse && (state_q == ST_SET_MIN);

    // Carries are gated by sec_wrap so an edit wrap never spills into the next field.
    assign sec_inc    = tick_en;
    assign min_inc    = sec_wrap || (edit_pulse && (state_q == ST_SET_MIN));
    assign hr_inc     = (sec_wrap && min_wrap) || (edit_pulse && (state_q == ST_SET_HR));
    assign al_hr_inc  = edit_pulse && (state_q == ST_SET_AL_HR);
    assign al_min_inc = edit_pulse && (state_q == ST_SET_AL_MIN);

    wrap_counter #(.W(MIN_W), .MAX(MIN_MAX), .RST_VAL('0)) u_sec (
        .clk(clk), .reset(reset), .inc(sec_inc), .clr(sec_clr),
        .value(seconds), .wrap(sec_wrap));

    wrap_counter #(.W(MIN_W), .MAX(MIN_MAX), .RST_VAL('0)) u_min (
        .clk(clk), .reset(reset), .inc(min_inc), .clr(1'b0),
        .value(minutes), .wrap(min_wrap));

    wrap_counter #(.W(HR_W), .MAX(HOUR_MAX), .RST_VAL('0)) u_hr (
        .clk(clk), .reset(reset), .inc(hr_inc), .clr(1'b0),
        .value(hours), .wrap(hr_wrap));

    wrap_counter #(.W(HR_W), .MAX(HOUR_MAX), .RST_VAL(AL_HR_RST)) u_al_hr (
        .clk(clk), .reset(reset), .inc(al_hr_inc), .clr(1'b0),
        .value(al_hours), .wrap(unused_al_hr_wrap));

    wrap_counter #(.W(MIN_W), .MAX(MIN_MAX), .RST_VAL(AL_MIN_RST)) u_al_min (
        .clk(clk), .reset(reset), .inc(al_min_inc), .clr(1'b0),
        .value(al_minutes), .wrap(unused_al_min_wrap));

    // Post-tick time, so the ring rises on the same edge that shows hh:mm:00.
    assign min_next = min_wrap ? '0 : minutes + 1'b1;
    assign hr_next  = hr_wrap ? '0 : (min_wrap ? hours + 1'b1 : hours);

    assign ring_start = (state_q == ST_RUN) && alarm_en_sw && sec_wrap
                        && (min_next == al_minutes) && (hr_next == al_hours);
    assign ring_clear = !alarm_en_sw || (state_q != ST_RUN) || mode_pulse || inc_pulse;

    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (ring_clear) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
        end else if (ring_start) begin
            ring_d     = 1'b1;
            ring_cnt_d = RING_W'(ALARM_LEN);
        end else if (ring_q && sec_tick) begin
            ring_cnt_d = ring_cnt_q - 1'b1;
            if (ring_cnt_q == RING_W'(1)) begin
                ring_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign edit_field = state_q;
    assign alarm_ring = ring_q;

endmodule

// File: tb/tb_alarm_time_controller.sv
// Directed bench for alarm_time_controller: editing, rollover, frozen time,
// alarm ring/silence, illegal-state recovery and asynchronous reset.
module tb_alarm_time_controller;
    import clock_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sec_tick = 1'b0;
    logic       mode_pulse = 1'b0;
    logic       inc_pulse = 1'b0;
    logic       alarm_en_sw = 1'b0;
    logic [4:0] hours, al_hours;
    logic [5:0] minutes, seconds, al_minutes;
    logic [2:0] edit_field;
    logic       alarm_ring;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    alarm_time_controller #(.ALARM_LEN(60)) dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick), .mode_pulse(mode_pulse),
        .inc_pulse(inc_pulse), .alarm_en_sw(alarm_en_sw), .hours(hours),
        .minutes(minutes), .seconds(seconds), .al_hours(al_hours),
        .al_minutes(al_minutes), .edit_field(edit_field), .alarm_ring(alarm_ring));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc(input logic t, input logic m, input logic i);
        sec_tick = t; mode_pulse = m; inc_pulse = i;
        @(posedge clk); #1;
        sec_tick = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0;
    endtask

    task automatic modes(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hr"}, hours, h);
        check({tag, "_min"}, minutes, m);
        check({tag, "_sec"}, seconds, s);
    endtask

    task automatic check_reset_vals(input string tag);
        check_time(tag, 0, 0, 0);
        check({tag, "_al_hr"}, al_hours, 6);
        check({tag, "_al_min"}, al_minutes, 30);
        check({tag, "_state"}, edit_field, 0);
        check({tag, "_ring"}, alarm_ring, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b1;

        // edit-field stepping and alarm edits
        modes(1); check("st1", edit_field, 1);
        modes(1); check("st2", edit_field, 2);
        modes(1); check("st3", edit_field, 3);
        incs(2);  check("al_hr_8", al_hours, 8);
        modes(1); check("st4", edit_field, 4);
        incs(1);  check("al_min_31", al_minutes, 31);
        modes(1); check("st0", edit_field, 0);

        // set 23:59, checking edit wraps never carry
        modes(1); incs(24);
        check("hr_edit_wrap", hours, 0);
        incs(23); check("hr_23", hours, 23);
        modes(1); incs(60);
        check("min_edit_wrap", minutes, 0);
        check("min_wrap_no_carry", hours, 23);
        incs(59);
        modes(3); check("back_run", edit_field, 0);
        ticks(59); check_time("t235959", 23, 59, 59);
        ticks(1);  check_time("rollover", 0, 0, 0);
        check("rollover_ring", alarm_ring, 0);

        // frozen time in SET_MIN, seconds cleared on leaving it
        ticks(42);
        modes(1); incs(10);
        modes(1); incs(15);
        check_time("t101542", 10, 15, 42);
        ticks(5); check_time("frozen", 10, 15, 42);
        modes(1); check_time("sec_clr", 10, 15, 0);
        check("st3_b", edit_field, 3);
        incs(22); check("al_hr_6", al_hours, 6);
        modes(1); incs(58);
        cyc(1'b1, 1'b0, 1'b1);
        check("tick_inc_al_min", al_minutes, 30);
        check("tick_inc_sec", seconds, 1);
        modes(1);

        // alarm 06:30 rings for 60 ticks
        modes(1); incs(20);
        modes(1); incs(14);
        modes(3); check_time("t062900", 6, 29, 0);
        alarm_en_sw = 1'b1;
        ticks(59); check("pre_match_ring", alarm_ring, 0);
        ticks(1);  check_time("match", 6, 30, 0);
        check("ring_on", alarm_ring, 1);
        ticks(59); check("ring_59", alarm_ring, 1);
        ticks(1);  check("ring_done", alarm_ring, 0);
        check("ring_done_min", minutes, 31);

        // ring silenced by INC in RUN
        modes(2); incs(58); modes(3);
        ticks(60); check("ring_on2", alarm_ring, 1);
        ticks(3);  check("ring_3", alarm_ring, 1);
        incs(1);   check("silenced", alarm_ring, 0);
        check_time("silence_time", 6, 30, 3);

        // MODE beats INC; illegal state recovers
        modes(1);
        cyc(1'b0, 1'b1, 1'b1);
        check("mode_wins_st", edit_field, 2);
        check("mode_wins_hr", hours, 6);
        force dut.state_q = state_e'(3'd6);
        #1;
        check("forced_st", edit_field, 6);
        @(posedge clk); #1;
        release dut.state_q;
        @(posedge clk); #1;
        check("illegal_recover", edit_field, 0);

        // asynchronous reset while ringing at 06:30:10
        modes(2); incs(59); modes(3);
        ticks(70);
        check_time("t063010", 6, 30, 10);
        check("ring_pre_rst", alarm_ring, 1);
        #2 reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        #2 reset = 1'b1;
        modes(1); check("post_rst_st", edit_field, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
